// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX path and the frame writer.
// Holds the TX state enum, the frame marker bytes and the baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic [7:0] SOM = 8'h73;
   localparam logic [7:0] EOM = 8'h65;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter for the UART transmitter.
// Ports: clk; restart (sync reload to CPB-1); tick (high one cycle per CPB).
module uart_baud_tick #(
   parameter int CPB = 434
) (
   input  logic clk,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(CPB);
   localparam logic [CW-1:0] LOAD = CW'(CPB - 1);

   logic [CW-1:0] cnt;

   // Reloading on every tick keeps bit boundaries exactly CPB apart.
   always_ff @(posedge clk) begin
      if (restart) begin
         cnt <= LOAD;
      end else if (cnt == '0) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte serializer driving the UART tx line (start, 8 data
// LSB first, optional even parity, 1 or 2 stop bits).
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_error/in_ready
// upstream handshake with fixed ready latency; tx line; busy; drop_cnt.
// Build option: define UART_TX_PARITY_EN to add the even parity bit.
module uart_byte_tx #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int BAUD          = 115_200,
   parameter int STOP_BITS     = 1,
   parameter int READY_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_error,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   import uart_pkg::*;

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int LW  = (READY_LATENCY < 1) ? 1 : $clog2(READY_LATENCY + 1);
   localparam logic [LW-1:0] LAT_MAX   = LW'(READY_LATENCY);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   if (CPB < 2) begin : g_bad_cpb
      $error("uart_byte_tx: CLK_HZ/BAUD must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
   end

   uart_tx_state_t state, state_n;
   logic [2:0]     bit_idx, bit_n, bit_nx;
   logic [LW-1:0]  lat, lat_n;
   logic [7:0]     data, data_n;
   logic [7:0]     drop_n;
   logic           tx_n, busy_n, ready_n;
   logic           start, tick, restart;

   assign bit_nx  = bit_idx + 3'd1;
   assign restart = reset | start;

   uart_baud_tick #(
      .CPB (CPB)
   ) u_baud (
      .clk     (clk),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_idx  <= '0;
         lat      <= '0;
         data     <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         in_ready <= 1'b1;
         drop_cnt <= '0;
      end else begin
         state    <= state_n;
         bit_idx  <= bit_n;
         lat      <= lat_n;
         data     <= data_n;
         tx       <= tx_n;
         busy     <= busy_n;
         in_ready <= ready_n;
         drop_cnt <= drop_n;
      end
   end

   always_comb begin
      state_n = state;
      bit_n   = bit_idx;
      lat_n   = '0;
      data_n  = data;
      drop_n  = drop_cnt;
      tx_n    = tx;
      busy_n  = busy;
      ready_n = in_ready;
      start   = 1'b0;
      unique case (state)
         IDLE: begin
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            ready_n = 1'b1;
            lat_n   = lat;
            if (in_ready) begin
               if (lat != LAT_MAX) begin
                  lat_n = lat + 1'b1;
               end else if (in_valid) begin
                  // Both outcomes drop in_ready so upstream sees a new rise.
                  lat_n   = '0;
                  ready_n = 1'b0;
                  if (in_error) begin
                     if (drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
                  end else begin
                     start   = 1'b1;
                     data_n  = in_data;
                     state_n = START;
                     tx_n    = 1'b0;
                     busy_n  = 1'b1;
                  end
               end
            end
         end
         START: begin
            if (tick) begin
               state_n = DATA;
               bit_n   = '0;
               tx_n    = data[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = ^data;
`else
                  state_n = STOP;
                  bit_n   = '0;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n = bit_nx;
                  tx_n  = data[bit_nx];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_n = STOP;
               bit_n   = '0;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (bit_idx == STOP_LAST) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  ready_n = 1'b1;
               end else begin
                  bit_n = bit_nx;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            ready_n = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte serializer that sits directly downstream of the UART frame writer. It accepts one byte at a time over a ready/valid handshake with fixed ready latency and drives the asynchronous `tx` line: start bit, 8 data bits LSB first, optional parity, stop bit(s). It is the physical TX stage of the signal-streaming link, paired with the host-side UART at a fixed baud rate.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115_200: line bit rate.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 and 2.
- `READY_LATENCY`, 2: cycles between the rising edge of `in_ready` and the first cycle `in_data`/`in_valid` may be sampled.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `in_data`, in, 8: byte to transmit.
- `in_valid`, in, 1: `in_data` is valid.
- `in_error`, in, 1: the byte is flagged bad; it is dropped, not sent.
- `in_ready`, out, 1: the block can take a byte.
- `tx`, out, 1: serial line, idle high.
- `busy`, out, 1: a frame is in progress.
- `drop_cnt`, out, 8: count of dropped bytes, saturating.

## Operation
- CPB = CLK_HZ / BAUD, integer division, computed at elaboration. CPB < 2 or STOP_BITS not in {1, 2} is an elaboration error.
- States:
  - IDLE: `in_ready`=1, `tx`=1. Entering IDLE clears the latency counter `lat`.
  - WAIT: internal to IDLE. `lat` increments each cycle `in_ready`=1 and saturates at READY_LATENCY.
  - Accept occurs on the first cycle with `lat`==READY_LATENCY and `in_valid`=1.
    - If `in_error`=1: `drop_cnt` increments (saturating at 255) and the block stays in IDLE with `lat` cleared. `in_ready` pulses low for one cycle, so the upstream sees a fresh rising edge.
    - Otherwise: `in_data` is latched into the shift register and the state goes to START.
- Transmit sequence:
  - START: `tx`=0 for CPB cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CPB cycles; bit index counts 0 to 7.
  - PARITY: only with the parity feature. Even parity bit, held CPB cycles.
  - STOP: `tx`=1 for STOP_BITS×CPB cycles, then IDLE.
- `busy`=1 in every state except IDLE. `in_ready` = IDLE and no drop pulse.
- `in_valid` held high continuously is legal. Each transmitted byte requires a fresh `in_ready` rise plus READY_LATENCY cycles, so stale data is never sent twice.
- `in_data` and `in_valid` are ignored outside the accept cycle.
- Reset mid-frame: the frame is aborted, `tx` goes to 1 on the next cycle, and the block returns to IDLE. A truncated frame on the line is accepted behaviour.

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `drop_cnt`=0, state IDLE, `lat`=0.
- All outputs are registered.
- Accept at cycle A: `tx` falls and `in_ready`/`busy` go to their transmit values at A+1.
- Frame length F = (10 + P + STOP_BITS − 1)×CPB cycles, where P = 1 with parity and 0 without. `tx` returns to idle after cycle A+F.
- `in_ready` rises at A+F+1; the earliest next accept is A+F+1+READY_LATENCY.
- Bit boundaries fall exactly every CPB cycles; the baud counter reloads on every bit with no cumulative drift.
- A drop at cycle D: `in_ready`=0 at D+1, back to 1 at D+2; `drop_cnt` is updated at D+1.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is included; the bit is the XOR of the 8 data bits (even parity); P=1.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent; P=0; frame is 8N1 or 8N2.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - frame constants SOM=8'h73 and EOM=8'h65, shared with the frame writer;
  - function `clks_per_bit(clk_hz, baud)`.
- One sub-module, `uart_baud_tick`: a CPB down-counter with a synchronous `restart` input and a one-cycle `tick` output; it is restarted on accept and on reset.

## Test plan
All scenarios use CLK_HZ=1_000_000, BAUD=100_000 (CPB=10), STOP_BITS=1, READY_LATENCY=2.
- Send 0xA5: sampling `tx` mid-bit gives 0,1,0,1,0,0,1,0,1,1 (no parity), each level 10 cycles; with parity, 0,1,0,1,0,0,1,0,1,0,1. `busy` high for 100 or 110 cycles.
- Hold `in_valid`=1 with upstream data 0x73 then 0x12, changed 2 cycles after each `in_ready` rise: exactly two frames appear, 0x73 then 0x12, with no repeat. `in_ready` rises 1 cycle after each stop bit ends.
- `in_valid`=1 with `in_error`=1 at accept: no `tx` activity, `drop_cnt` 0→1, `in_ready` low exactly 1 cycle. Repeating 300 times leaves `drop_cnt` saturated at 255.
- `in_valid` asserted 1 cycle after the `in_ready` rise (before latency elapses) and deasserted at cycle 2: no accept, `tx` stays 1.
- Assert `reset` during DATA bit 3 of 0xFF: `tx`=1, `busy`=0, `in_ready`=1 on the next cycle; the following 0x00 frame is bit-exact.
- Full s/0xDEADBEEF/e sequence from the frame writer: bytes 73 DE AD BE EF 65 appear on `tx` in order, back-to-back, with a 3-cycle gap between frames.
